// File: rtl/input_conditioner_if.sv
// Bundle of the conditioner's data-path signals: raw asynchronous inputs
// in, synchronised/filtered levels and edge strobes out.
//
// Handshake: there is no valid/ready pair. WIRE_IN is a free-running level
// that may change at any time. WIRE_OUT is a level. RISE and FALL are
// single-cycle strobes. Every output is meaningful on every rising CLK edge.
interface input_conditioner_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] WIRE_IN;
  logic [DATA_WIDTH-1:0] WIRE_OUT;
  logic [DATA_WIDTH-1:0] RISE;
  logic [DATA_WIDTH-1:0] FALL;

  // Driving side: produces the raw lines and consumes the conditioned ones.
  modport master (
    output WIRE_IN,
    input  WIRE_OUT,
    input  RISE,
    input  FALL
  );

  // Conditioner side.
  modport slave (
    input  WIRE_IN,
    output WIRE_OUT,
    output RISE,
    output FALL
  );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner.
//
// Each channel passes through a SYNC_STAGES-deep synchroniser and then a
// stability filter. The filter accepts a new level only after that level has
// been held for FILTER_CYCLES consecutive cycles at the synchroniser output.
//
// Optional macro INPUT_COND_EDGE_EN adds registered one-cycle RISE/FALL
// strobes. Without it, RISE and FALL are tied to 0 and no edge flops exist.
//
// Parameter legality: SYNC_STAGES >= 2, FILTER_CYCLES >= 1.
// RESET_VALUE is a single bit that is replicated across all channels.
// All state is cleared by a synchronous, active-low RST_N.
module input_conditioner #(
  parameter int   DATA_WIDTH    = 1,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VALUE   = 1'b0
) (
  input logic                CLK,
  input logic                RST_N,
  input_conditioner_if.slave bus
);

  localparam int             CW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_lvl;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;
  logic [CW-1:0]         cnt_q  [DATA_WIDTH];
  logic [CW-1:0]         cnt_d  [DATA_WIDTH];

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: a pure shift register with no logic between stages.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {DATA_WIDTH{RESET_VALUE}};
      end
    end else begin
      sync_q[0] <= bus.WIRE_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Filter decision per channel. Any cycle where the synchronised level
  // agrees with the output clears the count, so short excursions are dropped.
  always_comb begin
    out_d = out_q;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      cnt_d[c] = '0;
      if (sync_lvl[c] != out_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          out_d[c] = sync_lvl[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_ONE;
        end
      end
    end
  end

  // Filter state: per-channel stability counters and the accepted levels.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_q <= {DATA_WIDTH{RESET_VALUE}};
      for (int c = 0; c < DATA_WIDTH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      out_q <= out_d;
      for (int c = 0; c < DATA_WIDTH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign bus.WIRE_OUT = out_q;

`ifdef INPUT_COND_EDGE_EN
  logic [DATA_WIDTH-1:0] rise_q;
  logic [DATA_WIDTH-1:0] fall_q;

  // Edge strobes are registered from the same next-state as WIRE_OUT. They
  // therefore line up with the first cycle of the new level. A reset clears
  // them and never creates one.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= ~out_q & out_d;
      fall_q <= out_q & ~out_d;
    end
  end

  assign bus.RISE = rise_q;
  assign bus.FALL = fall_q;
`else
  assign bus.RISE = '0;
  assign bus.FALL = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with 4 channels, 2 sync stages, a 4-cycle
// filter and reset value 0.
//
// The reference model applies the filter rule directly. A channel's output
// flips when the last FILTER_CYCLES synchronised samples all differ from the
// current output. The synchronised value is the input from SYNC_STAGES edges
// earlier.
//
// Expected strobes depend on whether INPUT_COND_EDGE_EN is defined.
module tb_input_conditioner;

  localparam int   DW  = 4;
  localparam int   SS  = 2;
  localparam int   FC  = 4;
  localparam logic RV  = 1'b0;
  localparam logic [DW-1:0] RV4 = {DW{RV}};
`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  input_conditioner_if #(.DATA_WIDTH(DW)) bus ();

  input_conditioner #(
    .DATA_WIDTH   (DW),
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC),
    .RESET_VALUE  (RV)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // Clock: 10 ns period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DW-1:0] pipe_q [$];
  logic [DW-1:0] win_q  [$];
  logic [DW-1:0] m_out  = RV4;
  logic [DW-1:0] m_rise = '0;
  logic [DW-1:0] m_fall = '0;

  // Records one comparison and reports it if the observed value is wrong.
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advances the reference model by one rising edge.
  task automatic model_edge(input logic rst_n_v, input logic [DW-1:0] in_v);
    logic [DW-1:0] s;
    logic [DW-1:0] nxt;
    bit            all_diff;
    if (!rst_n_v) begin
      pipe_q = {};
      win_q  = {};
      repeat (SS) pipe_q.push_back(RV4);
      repeat (FC) win_q.push_back(RV4);
      m_out  = RV4;
      m_rise = '0;
      m_fall = '0;
    end else begin
      s = pipe_q.pop_front();
      pipe_q.push_back(in_v);
      win_q.push_back(s);
      void'(win_q.pop_front());
      nxt = m_out;
      for (int c = 0; c < DW; c++) begin
        all_diff = 1'b1;
        foreach (win_q[i]) begin
          if (win_q[i][c] == m_out[c]) all_diff = 1'b0;
        end
        if (all_diff) nxt[c] = ~m_out[c];
      end
      m_rise = EDGE_EN ? (~m_out & nxt) : '0;
      m_fall = EDGE_EN ? (m_out & ~nxt) : '0;
      m_out  = nxt;
    end
  endtask

  // Drives one cycle of stimulus, advances the model, and checks all outputs 1 ns after the edge.
  task automatic tick(input logic rst_n_v, input logic [DW-1:0] in_v);
    RST_N       = rst_n_v;
    bus.WIRE_IN = in_v;
    @(posedge CLK);
    model_edge(rst_n_v, in_v);
    #1;
    check("model_out",  bus.WIRE_OUT, m_out);
    check("model_rise", bus.RISE,     m_rise);
    check("model_fall", bus.FALL,     m_fall);
  endtask

  logic [DW-1:0] r_in;
  logic          r_rst;

  initial begin
    RST_N       = 1'b0;
    bus.WIRE_IN = 4'hF;

    // Reset held for 3 cycles with all inputs high.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'hF);
      check("rst_out",  bus.WIRE_OUT, 4'h0);
      check("rst_rise", bus.RISE,     4'h0);
      check("rst_fall", bus.FALL,     4'h0);
    end

    // Release: level appears 5 edges after the first post-reset edge.
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 4'hF);
      check("rel_out",  bus.WIRE_OUT, (j >= 5) ? 4'hF : 4'h0);
      check("rel_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'hF : 4'h0);
    end

    repeat (10) tick(1'b1, 4'h0);

    // Clean step on channel 0.
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 4'h1);
      check("step_out",  bus.WIRE_OUT, (j >= 5) ? 4'h1 : 4'h0);
      check("step_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'h1 : 4'h0);
      check("step_fall", bus.FALL,     4'h0);
    end

    // 3-cycle glitch on channel 1 is rejected.
    for (int j = 0; j < 12; j++) begin
      tick(1'b1, (j < 3) ? 4'h3 : 4'h1);
      check("glitch3_out",  bus.WIRE_OUT, 4'h1);
      check("glitch3_rise", bus.RISE,     4'h0);
    end

    // 4-cycle pulse on channel 1 is accepted.
    for (int j = 0; j < 14; j++) begin
      tick(1'b1, (j < 4) ? 4'h3 : 4'h1);
      check("pulse4_out",  bus.WIRE_OUT, (j >= 5 && j < 9) ? 4'h3 : 4'h1);
      check("pulse4_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'h2 : 4'h0);
      check("pulse4_fall", bus.FALL,     (j == 9 && EDGE_EN) ? 4'h2 : 4'h0);
    end

    repeat (10) tick(1'b1, 4'h0);

    // Simultaneous change on channels 0 and 2.
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 4'h5);
      check("sim1_out",  bus.WIRE_OUT, (j >= 5) ? 4'h5 : 4'h0);
      check("sim1_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'h5 : 4'h0);
    end
    repeat (4) tick(1'b1, 4'h5);

    // Simultaneous swap to channels 1 and 3.
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 4'hA);
      check("sim2_out",  bus.WIRE_OUT, (j >= 5) ? 4'hA : 4'h5);
      check("sim2_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'hA : 4'h0);
      check("sim2_fall", bus.FALL,     (j == 5 && EDGE_EN) ? 4'h5 : 4'h0);
    end

    repeat (10) tick(1'b1, 4'h0);

    // Reset mid-count on channel 2.
    tick(1'b1, 4'h4);
    tick(1'b1, 4'h4);
    tick(1'b0, 4'h4);
    check("midrst_out", bus.WIRE_OUT, 4'h0);
    for (int j = 0; j < 8; j++) begin
      tick(1'b1, 4'h4);
      check("midrst_out",  bus.WIRE_OUT, (j >= 5) ? 4'h4 : 4'h0);
      check("midrst_rise", bus.RISE,     (j == 5 && EDGE_EN) ? 4'h4 : 4'h0);
    end

    // Random stimulus: mostly short and long runs, with occasional resets.
    r_in = 4'h0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) r_in = 4'($urandom_range(0, 15));
      r_rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick(r_rst, r_in);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
